// File: rtl/histogram_accumulator.sv
// -----------------------------------------------------------------------------
// histogram_accumulator
//
// Builds the 2**PIXEL_WIDTH-bin intensity histogram of one frame from a
// streamed pixel input. A working set of bin counters accumulates the current
// frame. A separate output register holds the last completed histogram, so the
// published result stays stable while the next frame accumulates.
//
// Ports
//   i_clk              : clock, rising edge
//   i_rst_n            : asynchronous active-low reset
//   i_frame_start      : one-cycle pulse on the first cycle of a frame
//   i_frame_end        : one-cycle pulse on the last cycle of a frame
//   i_pixel_valid      : i_pixel carries a pixel this cycle
//   i_pixel            : pixel intensity, selects the bin to increment
//   o_histogram_flat   : published histogram, bin j at [COUNT_WIDTH*j +: COUNT_WIDTH]
//   o_histogram_valid  : one-cycle pulse when o_histogram_flat is updated
//   o_saturated        : some bin of the published frame tried to exceed all-ones
//   o_abort            : one-cycle pulse when a frame restarts before its end
//   o_busy             : high while a frame is being accumulated
// -----------------------------------------------------------------------------
module histogram_accumulator #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_frame_start,
  input  logic                                      i_frame_end,
  input  logic                                      i_pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]                    i_pixel,
  output logic [(2**PIXEL_WIDTH)*COUNT_WIDTH-1:0]   o_histogram_flat,
  output logic                                      o_histogram_valid,
  output logic                                      o_saturated,
  output logic                                      o_abort,
  output logic                                      o_busy
);

  localparam int BINS = 2**PIXEL_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Saturating increment: the sum is formed one bit wider so the carry out
  // tells us the counter was already at all-ones; in that case it holds.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, value} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    return sum[COUNT_WIDTH] ? value : sum[COUNT_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_t state_reg, state_next;

  // Working bins live in flops rather than block RAM: publish and abort clear
  // every bin in a single cycle, which a RAM port cannot do.
  logic [BINS-1:0][COUNT_WIDTH-1:0] bin_reg;
  logic [BINS-1:0][COUNT_WIDTH-1:0] bin_next;
  logic [BINS-1:0][COUNT_WIDTH-1:0] bin_inc;   // bins with this cycle's pixel added
  logic [BINS-1:0]                  hit_vec;   // one-hot: bin selected by an accepted pixel
  logic [BINS-1:0]                  ovf_vec;   // selected bin is already at all-ones

  logic work_sat_reg, work_sat_next;

  logic [BINS*COUNT_WIDTH-1:0] hist_reg;
  logic                        out_sat_reg;
  logic                        valid_reg;
  logic                        abort_reg;
  logic                        busy_reg;

  // Decoded events for the current cycle
  logic accept;       // pixel is counted this cycle
  logic abort_evt;    // frame restarted while accumulating
  logic publish_evt;  // frame completed normally
  logic sat_hit;      // accepted pixel hit a bin already at all-ones

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    abort_evt   = 1'b0;
    publish_evt = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Pixels and frame ends are ignored until a frame starts; the start
        // cycle's own pixel is the first pixel of the frame.
        if (i_frame_start) begin
          state_next = ST_ACCUM;
          accept     = i_pixel_valid;
        end
      end
      ST_ACCUM: begin
        accept = i_pixel_valid;
        if (i_frame_start) begin
          // A restart takes priority over a coincident end: nothing publishes.
          abort_evt  = 1'b1;
          state_next = ST_ACCUM;
        end else if (i_frame_end) begin
          publish_evt = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-bin datapath
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < BINS; gi++) begin : g_bin
      assign hit_vec[gi] = accept && (i_pixel == PIXEL_WIDTH'(gi));
      assign ovf_vec[gi] = hit_vec[gi] && (&bin_reg[gi]);
      assign bin_inc[gi] = hit_vec[gi] ? sat_inc(bin_reg[gi]) : bin_reg[gi];

      // On publish everything clears. On abort the old contents are discarded
      // and only the restart cycle's pixel survives, so the bin is 0 or 1.
      assign bin_next[gi] = publish_evt ? {COUNT_WIDTH{1'b0}}
                          : abort_evt   ? {{(COUNT_WIDTH-1){1'b0}}, hit_vec[gi]}
                          :               bin_inc[gi];
    end
  endgenerate

  // An overflow against the old bin contents does not count on abort, since
  // that pixel lands in a freshly cleared bin.
  assign sat_hit = (|ovf_vec) && !abort_evt;

  always_comb begin
    work_sat_next = work_sat_reg;
    if (publish_evt || abort_evt) begin
      work_sat_next = 1'b0;
    end else if (accept) begin
      work_sat_next = work_sat_reg | sat_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      bin_reg      <= '0;
      work_sat_reg <= 1'b0;
      hist_reg     <= '0;
      out_sat_reg  <= 1'b0;
      valid_reg    <= 1'b0;
      abort_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      work_sat_reg <= work_sat_next;
      valid_reg    <= publish_evt;
      abort_reg    <= abort_evt;
      busy_reg     <= (state_next == ST_ACCUM);
      // The published image includes the pixel arriving with the frame end.
      if (publish_evt) begin
        hist_reg    <= bin_inc;
        out_sat_reg <= work_sat_reg | sat_hit;
      end
    end
  end

  assign o_histogram_flat  = hist_reg;
  assign o_histogram_valid = valid_reg;
  assign o_saturated       = out_sat_reg;
  assign o_abort           = abort_reg;
  assign o_busy            = busy_reg;

endmodule
